// File: rtl/fetch_imem_if.sv
// Request/valid handshake between the fetch stage and instruction memory or I-cache.
// The fetch stage is the master; the memory side is the slave.
interface fetch_imem_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;

  modport master (output imem_req, output imem_addr, input imem_data, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_data, output imem_valid);
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage plus IF/ID pipeline register.
// It keeps one memory transfer outstanding, honours decode stall/flush, and stops fetching on HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'hE000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic [15:0]   branch_pc,
  fetch_imem_if.master  imem,
  output logic [15:0]   curr_pc_fd,
  output logic [15:0]   next_pc_fd,
  output logic [15:0]   curr_instr_fd,
  output logic          valid_fd,
  output logic          halted
);

  typedef enum logic [1:0] {FETCH, DRAIN, HOLD, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] redirect_q, redirect_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] cpc_q, cpc_d;
  logic [15:0] npc_q, npc_d;
  logic [15:0] instr_q, instr_d;
  logic        vfd_q, vfd_d;

  logic        ifLoad;
  logic        ifBubble;
  logic [15:0] loadWord;
  logic [15:0] pcPlus2;

  assign pcPlus2        = pc_q + 16'd2;
  assign imem.imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  // The address is the PC register itself, so it cannot move until the FSM retires the transfer.
  assign imem.imem_addr = pc_q;
  assign halted         = (state_q == HALT);
  assign curr_pc_fd     = cpc_q;
  assign next_pc_fd     = npc_q;
  assign curr_instr_fd  = instr_q;
  assign valid_fd       = vfd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      redirect_q <= RESET_PC;
      buf_q      <= NOP_INSTR;
      cpc_q      <= 16'h0000;
      npc_q      <= 16'h0000;
      instr_q    <= NOP_INSTR;
      vfd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      buf_q      <= buf_d;
      cpc_q      <= cpc_d;
      npc_q      <= npc_d;
      instr_q    <= instr_d;
      vfd_q      <= vfd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    buf_d      = buf_q;
    ifLoad     = 1'b0;
    ifBubble   = 1'b0;
    loadWord   = imem.imem_data;

    unique case (state_q)
      FETCH: begin
        if (imem.imem_valid) begin
          if (flush) begin
            pc_d     = branch_pc;
            ifBubble = 1'b1;
          end else if (stall) begin
            buf_d   = imem.imem_data;
            state_d = HOLD;
          end else begin
            ifLoad = 1'b1;
            pc_d   = pcPlus2;
            if (imem.imem_data[15:12] == HLT_OPCODE) state_d = HALT;
          end
        end else if (flush) begin
          redirect_d = branch_pc;
          ifBubble   = 1'b1;
          state_d    = DRAIN;
        end else if (!stall) begin
          ifBubble = 1'b1;
        end
      end
      DRAIN: begin
        // The word coming back belongs to the wrong path; only its completion matters.
        if (flush) redirect_d = branch_pc;
        if (imem.imem_valid) begin
          pc_d    = flush ? branch_pc : redirect_q;
          state_d = FETCH;
        end
        ifBubble = !(stall && !flush);
      end
      HOLD: begin
        loadWord = buf_q;
        if (flush) begin
          pc_d     = branch_pc;
          ifBubble = 1'b1;
          state_d  = FETCH;
        end else if (!stall) begin
          ifLoad  = 1'b1;
          pc_d    = pcPlus2;
          state_d = (buf_q[15:12] == HLT_OPCODE) ? HALT : FETCH;
        end
      end
      HALT: begin
        if (flush) begin
          pc_d     = branch_pc;
          ifBubble = 1'b1;
          state_d  = FETCH;
        end else if (!stall) begin
          ifBubble = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase

    cpc_d   = cpc_q;
    npc_d   = npc_q;
    instr_d = instr_q;
    vfd_d   = vfd_q;
    if (ifLoad) begin
      cpc_d   = pc_q;
      npc_d   = pcPlus2;
      instr_d = loadWord;
      vfd_d   = 1'b1;
    end else if (ifBubble) begin
      instr_d = NOP_INSTR;
      vfd_d   = 1'b0;
    end
  end

endmodule
